// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs a req/ack handshake to
// instruction memory and drives the fetch->decode pipeline register.
//
// Ports:
//   i_clk, i_arst                 clock, synchronous active-high reset
//   i_stall_fetch                 hold PC and output register
//   i_flush_decode                load a bubble into the output register
//   i_redirect, i_pc_target       taken branch/jump from exec
//   o_imem_req, o_imem_addr       memory request (addr = pc_q)
//   i_imem_ack, i_imem_rdata      memory response, rdata valid in the ack cycle
//   o_instruction, o_pc,
//   o_pc_plus4                    registered outputs to decode
module fetch_stage #(
    parameter int unsigned             ADDR_WIDTH  = 64,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_fetch,
    input  logic                   i_flush_decode,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_pc_target,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4
);

    typedef enum logic [1:0] {StFetch, StHold, StKill} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  saved_tgt_q, saved_tgt_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic [ADDR_WIDTH-1:0]  out_pc4_q, out_pc4_d;

    logic [ADDR_WIDTH-1:0]  tgt;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic                   load_bubble;

    // No compressed ISA: targets are always word aligned.
    assign tgt      = {i_pc_target[ADDR_WIDTH-1:2], 2'b00};
    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    assign o_imem_req    = !i_arst && (state_q == StFetch || state_q == StKill);
    assign o_imem_addr   = pc_q;
    assign o_instruction = out_instr_q;
    assign o_pc          = out_pc_q;
    assign o_pc_plus4    = out_pc4_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        saved_tgt_d  = saved_tgt_q;
        skid_instr_d = skid_instr_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        load_bubble  = 1'b0;

        case (state_q)
            StFetch: begin
                if (i_redirect) begin
                    load_bubble = 1'b1;
                    if (i_imem_ack) begin
                        pc_d = tgt;
                    end else begin
                        // Request still outstanding: addr must stay put until its ack.
                        saved_tgt_d = tgt;
                        state_d     = StKill;
                    end
                end else if (i_imem_ack && !i_stall_fetch) begin
                    out_instr_d = i_imem_rdata;
                    out_pc_d    = pc_q;
                    out_pc4_d   = pc_plus4;
                    pc_d        = pc_plus4;
                end else if (i_imem_ack) begin
                    // pc_q keeps the address of the buffered instruction.
                    skid_instr_d = i_imem_rdata;
                    state_d      = StHold;
                end else if (!i_stall_fetch) begin
                    load_bubble = 1'b1;
                end
            end
            StHold: begin
                if (i_redirect) begin
                    load_bubble = 1'b1;
                    pc_d        = tgt;
                    state_d     = StFetch;
                end else if (!i_stall_fetch) begin
                    out_instr_d = skid_instr_q;
                    out_pc_d    = pc_q;
                    out_pc4_d   = pc_plus4;
                    pc_d        = pc_plus4;
                    state_d     = StFetch;
                end
            end
            StKill: begin
                if (i_redirect) begin
                    saved_tgt_d = tgt;
                end
                if (i_imem_ack) begin
                    pc_d    = i_redirect ? tgt : saved_tgt_q;
                    state_d = StFetch;
                end
                if (i_redirect || !i_stall_fetch) begin
                    load_bubble = 1'b1;
                end
            end
            default: state_d = StFetch;
        endcase

        if (load_bubble || i_flush_decode) begin
            out_instr_d = NOP_INSTR;
            out_pc_d    = '0;
            out_pc4_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            saved_tgt_q  <= '0;
            skid_instr_q <= NOP_INSTR;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= '0;
            out_pc4_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            saved_tgt_q  <= saved_tgt_d;
            skid_instr_q <= skid_instr_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        arst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [63:0] pc_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic [63:0] pc_plus4;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] Nop = 32'h0000_0013;

    fetch_stage dut (
        .i_clk          (clk),
        .i_arst         (arst),
        .i_stall_fetch  (stall),
        .i_flush_decode (flush),
        .i_redirect     (redirect),
        .i_pc_target    (pc_target),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_ack     (imem_ack),
        .i_imem_rdata   (imem_rdata),
        .o_instruction  (instruction),
        .o_pc           (pc),
        .o_pc_plus4     (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] ins,
                             input logic [63:0] p, input logic [63:0] p4);
        check_eq({tag, ".instr"}, {32'h0, instruction}, {32'h0, ins});
        check_eq({tag, ".pc"}, pc, p);
        check_eq({tag, ".pc4"}, pc_plus4, p4);
    endtask

    initial begin
        arst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        pc_target = '0; imem_ack = 1'b0; imem_rdata = '0;
        #1;
        check_eq("rst.req_low", {63'h0, imem_req}, 64'd0);
        tick();
        tick();
        arst = 1'b0;
        #1;
        check_out("rst", Nop, 64'h0, 64'h0);
        check_eq("rst.addr", imem_addr, 64'h0);
        check_eq("rst.req", {63'h0, imem_req}, 64'd1);

        // 1: zero-wait ack
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        imem_ack = 1'b0;
        check_out("t1", 32'h0050_0093, 64'h0, 64'h4);
        check_eq("t1.addr", imem_addr, 64'h4);

        // 2: three-cycle ack delay
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("t2.bubble", Nop, 64'h0, 64'h0);
            check_eq("t2.addr", imem_addr, 64'h4);
        end
        imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
        tick();
        imem_ack = 1'b0;
        check_out("t2", 32'h00A0_0113, 64'h4, 64'h8);
        check_eq("t2.addr_next", imem_addr, 64'h8);

        // 3: ack while stalled goes to skid buffer
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0020_8193;
        tick();
        imem_ack = 1'b0;
        check_out("t3.hold1", 32'h00A0_0113, 64'h4, 64'h8);
        check_eq("t3.req1", {63'h0, imem_req}, 64'd0);
        tick();
        check_out("t3.hold2", 32'h00A0_0113, 64'h4, 64'h8);
        check_eq("t3.req2", {63'h0, imem_req}, 64'd0);
        stall = 1'b0;
        tick();
        check_out("t3", 32'h0020_8193, 64'h8, 64'hC);
        check_eq("t3.addr", imem_addr, 64'hC);
        check_eq("t3.req", {63'h0, imem_req}, 64'd1);

        // 4: redirect while 0xC outstanding
        redirect = 1'b1; pc_target = 64'h103;
        tick();
        redirect = 1'b0;
        check_out("t4.bub1", Nop, 64'h0, 64'h0);
        check_eq("t4.addr_old", imem_addr, 64'hC);
        check_eq("t4.req", {63'h0, imem_req}, 64'd1);
        tick();
        check_eq("t4.addr_old2", imem_addr, 64'hC);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check_out("t4.discard", Nop, 64'h0, 64'h0);
        check_eq("t4.addr_new", imem_addr, 64'h100);

        // 5: flush beats stall
        imem_ack = 1'b1; imem_rdata = 32'h0000_0513;
        tick();
        imem_ack = 1'b0;
        check_out("t5.pre", 32'h0000_0513, 64'h100, 64'h104);
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        check_out("t5", Nop, 64'h0, 64'h0);

        // wrap: redirect with ack in FETCH, then PC+4 past the top
        redirect = 1'b1; pc_target = 64'hFFFF_FFFF_FFFF_FFFF; imem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        redirect = 1'b0;
        check_out("wrap.bub", Nop, 64'h0, 64'h0);
        check_eq("wrap.addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_rdata = 32'h0000_0593;
        tick();
        imem_ack = 1'b0;
        check_out("wrap", 32'h0000_0593, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        check_eq("wrap.addr_next", imem_addr, 64'h0);

        // 6: reset in KILL
        redirect = 1'b1; pc_target = 64'h200;
        tick();
        redirect = 1'b0;
        check_eq("t6.kill_addr", imem_addr, 64'h0);
        arst = 1'b1;
        #1;
        check_eq("t6.req_rst", {63'h0, imem_req}, 64'd0);
        tick();
        arst = 1'b0;
        #1;
        check_out("t6.rst", Nop, 64'h0, 64'h0);
        check_eq("t6.addr", imem_addr, 64'h0);
        check_eq("t6.req", {63'h0, imem_req}, 64'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0010_0093;
        tick();
        imem_ack = 1'b0;
        check_out("t6.after", 32'h0010_0093, 64'h0, 64'h4);
        check_eq("t6.addr_next", imem_addr, 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
